mut_mem_fi: RTL and testbench
=============================

# mut_mem_fi

Parametrised memory-under-test wrapper for the PMBIST datapath with a built-in fault-injection table. It holds an inferred single-port RAM of 2^AW x DW words, decodes read/write commands from the march sequencer, and returns read data after a fixed, parametrised latency with a valid strobe. Up to NF programmable single-bit faults (stuck-at and transition) are overlaid on the array, so the BIST controller and comparator can be proven to detect them.

## Interface
- DW, `DATA_WIDTH, data word width
- AW, `ADDR_WIDTH, address width; depth = 2^AW
- CW, `MARCH_SEQ_FRMT_SIZE, command width; CW >= 2
- RD_LAT, 1, read latency in cycles; legal 1 or 2
- NF, 4, number of fault slots; 1..8
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- cmd_in  in  CW  bit0 = write, bit1 = read; other bits ignored
- addr_in  in  AW  word address
- data_in  in  DW  write data
- data_out  out  DW  read data
- data_vld  out  1  data_out valid, one-cycle pulse per read
- flt_wr  in  1  program one fault slot this cycle
- flt_idx  in  clog2(NF)  slot index
- flt_en  in  1  slot enable
- flt_type  in  2  00 SA0, 01 SA1, 10 TF_UP (0->1 fails), 11 TF_DN (1->0 fails)
- flt_addr  in  AW  faulty word address
- flt_bit  in  clog2(DW)  faulty bit index
- flt_val  in  1  initial value of the faulty bit (transition types)

## Operation
- Array is not reset; contents undefined after power-up/reset.
- Write (bit0=1): mem[addr_in] <= data_in; the faulty bit position still stores data_in, and the fault is applied through the overlay below.
- Read (bit1=1): array read synchronously; read-first: a simultaneous write to the same address returns the old word.
- Both bits set: write and read both performed, read-first.
- Each slot holds en, type, addr, bit, and a state bit fb_q.
  - SA0/SA1: read data bit forced to 0/1; fb_q unused.
  - TF_UP: on a write hitting the slot, fb_q <= fb_q ? data_in[bit] : 0.
  - TF_DN: on a write hitting the slot, fb_q <= fb_q ? 1 : data_in[bit].
  - Transition types: read data bit replaced by fb_q.
- Hit = en && addr_in == flt_addr. Several slots on the same address/bit: lowest index wins for read override; every hitting slot updates its own fb_q.
- flt_wr loads the slot and sets fb_q <= flt_val. If it coincides with a write hitting the same slot, the programming wins.
- Read overlay uses table state as of the issue cycle, before that cycle's updates. Reads already in flight are unaffected by later programming.
- flt_idx >= NF: flt_wr is ignored.

## Timing
- Read issued at rising edge N: data_out/data_vld valid after edge N+RD_LAT; data_vld high for exactly one cycle.
- Back-to-back reads are fully pipelined, one result per cycle.
- data_out holds its last value when data_vld = 0.
- Reset (async assert): data_out = 0, data_vld = 0, all slots en = 0, fb_q = 0, read pipeline flushed. In-flight reads are dropped; no data_vld after reset release.
- Writes take effect at the issuing edge; a read of the same address at N+1 sees the new word.

## Structure
- Shared package pmbist_mem_pkg holds the fault type encodings (SA0, SA1, TF_UP, TF_DN), the cmd bit positions (CMD_WR = 0, CMD_RD = 1), and the RD_LAT legal range.
- Sub-module mut_fault_slot, instantiated NF times. It holds the slot registers and fb_q update, and outputs hit, force-enable and force-value for the issue-cycle overlay. The top level does priority selection, the RAM and the RD_LAT pipeline.

## Test plan
- Write 0xA5 to addr 0x10, read at the next cycle: data_out = 0xA5 and data_vld one pulse, RD_LAT cycles after the read; repeat with RD_LAT=2.
- Slot0 SA1, addr 0x10, bit 1; write 0x00, read: 0x02. Disable slot0, read again: 0x00.
- Slot1 TF_UP, addr 0x20, bit 0, flt_val 0; write 0x01, read: 0x00. Write 0x00, then 0x01, read: 0x00. Reprogram with flt_val 1, read: 0x01.
- Same-cycle write 0x3C and read at addr 0x05 (old 0x11): returns 0x11; next read returns 0x3C.
- Slot0 SA0 and slot2 SA1 on the same address/bit: read shows 0 (slot0 wins).
- Assert rst while 2 reads are in flight: data_out = 0 and data_vld = 0 immediately; no data_vld after release; fault table disabled.

Source files
------------

// File: rtl/pmbist_mem_pkg.sv
// pmbist_mem_pkg: shared encodings for the PMBIST memory-under-test datapath
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef MARCH_SEQ_FRMT_SIZE
`define MARCH_SEQ_FRMT_SIZE 4
`endif
package pmbist_mem_pkg;
  typedef enum logic [1:0] {FT_SA0 = 2'b00, FT_SA1 = 2'b01, FT_TF_UP = 2'b10, FT_TF_DN = 2'b11} flt_type_e;
  localparam int CMD_WR = 0;
  localparam int CMD_RD = 1;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;
endpackage

// File: rtl/mut_fault_slot.sv
// mut_fault_slot: one programmable single-bit fault with its transition state bit
module mut_fault_slot
  import pmbist_mem_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int BW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_i,
  input  logic          en_i,
  input  logic [1:0]    type_i,
  input  logic [AW-1:0] faddr_i,
  input  logic [BW-1:0] fbit_i,
  input  logic          fval_i,
  input  logic          wr_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdat_i,
  output logic          frc_en_o,
  output logic          frc_val_o,
  output logic [BW-1:0] frc_bit_o
);
  logic          en_q, fb_q, fb_d, hit;
  flt_type_e     typ_q;
  logic [AW-1:0] addr_q;
  logic [BW-1:0] bit_q;
  assign hit = en_q && addr_i == addr_q;
  // TF_UP can only lose a 1 (fb&d), TF_DN can only lose a 0 (fb|d)
  assign fb_d = typ_q == FT_TF_UP ? fb_q & wdat_i[bit_q] :
                typ_q == FT_TF_DN ? fb_q | wdat_i[bit_q] : fb_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      en_q   <= 1'b0;
      typ_q  <= FT_SA0;
      addr_q <= '0;
      bit_q  <= '0;
      fb_q   <= 1'b0;
    end else if (ld_i) begin
      en_q   <= en_i;
      typ_q  <= flt_type_e'(type_i);
      addr_q <= faddr_i;
      bit_q  <= fbit_i;
      fb_q   <= fval_i;
    end else if (wr_i && hit) fb_q <= fb_d;
  assign frc_en_o  = hit;
  assign frc_val_o = typ_q == FT_SA0 ? 1'b0 : typ_q == FT_SA1 ? 1'b1 : fb_q;
  assign frc_bit_o = bit_q;
endmodule

// File: rtl/mut_mem_fi.sv
// mut_mem_fi: single-port RAM under test with fixed-latency reads and fault overlay
module mut_mem_fi
  import pmbist_mem_pkg::*;
#(
  parameter int DW     = `DATA_WIDTH,
  parameter int AW     = `ADDR_WIDTH,
  parameter int CW     = `MARCH_SEQ_FRMT_SIZE,
  parameter int RD_LAT = 1,
  parameter int NF     = 4,
  parameter int IW     = NF > 1 ? $clog2(NF) : 1,
  parameter int BW     = DW > 1 ? $clog2(DW) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] cmd_in,
  input  logic [AW-1:0] addr_in,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out,
  output logic          data_vld,
  input  logic          flt_wr,
  input  logic [IW-1:0] flt_idx,
  input  logic          flt_en,
  input  logic [1:0]    flt_type,
  input  logic [AW-1:0] flt_addr,
  input  logic [BW-1:0] flt_bit,
  input  logic          flt_val
);
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdat_q, m_q, v_q, fmask, fval, word, last_w;
  logic [NF-1:0] frc_en, frc_val;
  logic [BW-1:0] frc_bit [NF];
  logic          v1_q, last_v, unused_cmd;
  assign unused_cmd = ^cmd_in;
  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("mut_mem_fi: RD_LAT must be 1 or 2");
  end
  for (genvar i = 0; i < NF; i++) begin : g_slot
    mut_fault_slot #(.AW(AW), .DW(DW), .BW(BW)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .ld_i      (flt_wr && flt_idx == IW'(i)),
      .en_i      (flt_en),
      .type_i    (flt_type),
      .faddr_i   (flt_addr),
      .fbit_i    (flt_bit),
      .fval_i    (flt_val),
      .wr_i      (cmd_in[CMD_WR]),
      .addr_i    (addr_in),
      .wdat_i    (data_in),
      .frc_en_o  (frc_en[i]),
      .frc_val_o (frc_val[i]),
      .frc_bit_o (frc_bit[i])
    );
  end
  // walk from the top so the lowest-index slot on a bit overwrites the others
  always_comb begin
    fmask = '0;
    fval  = '0;
    for (int k = NF - 1; k >= 0; k--)
      if (frc_en[k]) begin
        fmask = fmask | (DW'(1) << frc_bit[k]);
        fval  = frc_val[k] ? fval | (DW'(1) << frc_bit[k]) : fval & ~(DW'(1) << frc_bit[k]);
      end
  end
  always_ff @(posedge clk) begin
    if (cmd_in[CMD_WR]) mem[addr_in] <= data_in;
    if (cmd_in[CMD_RD]) rdat_q <= mem[addr_in];
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      v1_q <= 1'b0;
      m_q  <= '0;
      v_q  <= '0;
    end else begin
      v1_q <= cmd_in[CMD_RD];
      m_q  <= fmask;
      v_q  <= fval;
    end
  assign word = (rdat_q & ~m_q) | (v_q & m_q);
  if (RD_LAT == 2) begin : g_lat2
    logic [DW-1:0] w2_q;
    logic          v2_q;
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        w2_q <= '0;
        v2_q <= 1'b0;
      end else begin
        w2_q <= word;
        v2_q <= v1_q;
      end
    assign last_w = w2_q;
    assign last_v = v2_q;
  end else begin : g_lat1
    assign last_w = word;
    assign last_v = v1_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      data_out <= '0;
      data_vld <= 1'b0;
    end else begin
      data_vld <= last_v;
      if (last_v) data_out <= last_w;
    end
endmodule

// File: tb/tb_mut_mem_fi.sv
// tb_mut_mem_fi: randomized scoreboard bench running RD_LAT=1 and RD_LAT=2 instances side by side
module tb_mut_mem_fi;
  localparam int DW = 8, AW = 8, CW = 4, NF = 3, IW = 2, BW = 3;
  logic clk = 1'b0, rst = 1'b1;
  logic [CW-1:0] cmd_in = '0;
  logic [AW-1:0] addr_in = '0, flt_addr = '0;
  logic [DW-1:0] data_in = '0, dout1, dout2, last1 = '0, last2 = '0;
  logic [IW-1:0] flt_idx = '0;
  logic [1:0]    flt_type = '0;
  logic [BW-1:0] flt_bit = '0;
  logic flt_wr = 1'b0, flt_en = 1'b0, flt_val = 1'b0, vld1, vld2;
  int total = 0, bad = 0, cnt = 0;
  typedef struct {logic [DW-1:0] d; int c; bit k;} exp_t;
  exp_t q1[$], q2[$];
  logic [DW-1:0] mem_m [2**AW];
  bit known [2**AW];
  bit s_en [NF], s_fb [NF];
  logic [1:0]    s_ty [NF];
  logic [AW-1:0] s_ad [NF];
  logic [BW-1:0] s_bt [NF];

  mut_mem_fi #(.DW(DW), .AW(AW), .CW(CW), .RD_LAT(1), .NF(NF)) u_l1 (
    .clk(clk), .rst(rst), .cmd_in(cmd_in), .addr_in(addr_in), .data_in(data_in),
    .data_out(dout1), .data_vld(vld1), .flt_wr(flt_wr), .flt_idx(flt_idx), .flt_en(flt_en),
    .flt_type(flt_type), .flt_addr(flt_addr), .flt_bit(flt_bit), .flt_val(flt_val));
  mut_mem_fi #(.DW(DW), .AW(AW), .CW(CW), .RD_LAT(2), .NF(NF)) u_l2 (
    .clk(clk), .rst(rst), .cmd_in(cmd_in), .addr_in(addr_in), .data_in(data_in),
    .data_out(dout2), .data_vld(vld2), .flt_wr(flt_wr), .flt_idx(flt_idx), .flt_en(flt_en),
    .flt_type(flt_type), .flt_addr(flt_addr), .flt_bit(flt_bit), .flt_val(flt_val));

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", n, act, exp, $time);
    end
  endtask

  // per-bit lookup of the lowest enabled slot targeting that bit of the word
  function automatic logic [DW-1:0] mread(input logic [AW-1:0] a);
    logic [DW-1:0] w = mem_m[a];
    for (int b = 0; b < DW; b++) begin
      int win = NF;
      for (int j = 0; j < NF && win == NF; j++)
        if (s_en[j] && s_ad[j] == a && int'(s_bt[j]) == b) win = j;
      if (win < NF) w[b] = s_ty[win] == 2'b00 ? 1'b0 : s_ty[win] == 2'b01 ? 1'b1 : s_fb[win];
    end
    return w;
  endfunction

  task automatic step(input logic [CW-1:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input bit fw = 0, input int fi = 0, input bit fe = 0, input logic [1:0] ft = 0,
                      input logic [AW-1:0] fa = 0, input logic [BW-1:0] fb = 0, input bit fv = 0);
    exp_t e;
    bit x;
    cmd_in = c; addr_in = a; data_in = d;
    flt_wr = fw; flt_idx = IW'(fi); flt_en = fe; flt_type = ft; flt_addr = fa; flt_bit = fb; flt_val = fv;
    if (c[1]) begin
      e.d = mread(a); e.k = known[a];
      e.c = cnt + 2; q1.push_back(e);
      e.c = cnt + 3; q2.push_back(e);
    end
    for (int k = 0; k < NF; k++)
      if (fw && fi == k) begin
        s_en[k] = fe; s_ty[k] = ft; s_ad[k] = fa; s_bt[k] = fb; s_fb[k] = fv;
      end else if (c[0] && s_en[k] && s_ad[k] == a) begin
        x = d[s_bt[k]];
        if (s_ty[k] == 2'b10) s_fb[k] = s_fb[k] ? x : 1'b0;
        else if (s_ty[k] == 2'b11) s_fb[k] = s_fb[k] ? 1'b1 : x;
      end
    if (c[0]) begin mem_m[a] = d; known[a] = 1; end
    @(posedge clk); #1;
  endtask

  task automatic mon(input int l, input logic v, input logic [DW-1:0] dv);
    exp_t e;
    int sz = (l == 1) ? q1.size() : q2.size();
    if (!v) begin
      chk($sformatf("L%0d hold", l), dv, (l == 1) ? last1 : last2);
      return;
    end
    chk($sformatf("L%0d vld_expected", l), sz > 0, 1);
    if (sz == 0) return;
    if (l == 1) e = q1.pop_front(); else e = q2.pop_front();
    chk($sformatf("L%0d latency", l), cnt, e.c);
    if (e.k) chk($sformatf("L%0d data", l), dv, e.d);
    if (l == 1) last1 = dv; else last2 = dv;
  endtask

  always @(negedge clk) begin
    mon(1, vld1, dout1);
    mon(2, vld2, dout2);
  end

  task automatic do_reset();
    rst = 1'b0;
    q1.delete(); q2.delete();
    last1 = '0; last2 = '0;
    for (int k = 0; k < NF; k++) begin s_en[k] = 0; s_fb[k] = 0; end
    for (int a = 0; a < 2**AW; a++) known[a] = 0;
    #1;
    chk("rst dout1", dout1, 0); chk("rst vld1", vld1, 0);
    chk("rst dout2", dout2, 0); chk("rst vld2", vld2, 0);
  endtask

  initial begin
    #2 do_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    for (int a = 0; a < 2**AW; a++) step(1, AW'(a), DW'($urandom));
    // basic write then read
    step(1, 8'h10, 8'hA5); step(2, 8'h10, 0); step(0, 0, 0);
    // SA1 on bit 1, then disable
    step(0, 0, 0, 1, 0, 1, 2'b01, 8'h10, 1);
    step(1, 8'h10, 8'h00); step(2, 8'h10, 0);
    step(0, 0, 0, 1, 0, 0, 2'b01, 8'h10, 1);
    step(2, 8'h10, 0);
    // TF_UP on slot1
    step(0, 0, 0, 1, 1, 1, 2'b10, 8'h20, 0, 0);
    step(1, 8'h20, 8'h01); step(2, 8'h20, 0);
    step(1, 8'h20, 8'h00); step(1, 8'h20, 8'h01); step(2, 8'h20, 0);
    step(0, 0, 0, 1, 1, 1, 2'b10, 8'h20, 0, 1);
    step(2, 8'h20, 0);
    // programming beats a coincident hitting write; read sees pre-update table
    step(1, 8'h20, 8'h00, 1, 1, 1, 2'b10, 8'h20, 0, 1);
    step(2, 8'h20, 0, 1, 1, 0, 2'b10, 8'h20, 0, 0);
    step(2, 8'h20, 0);
    // read-first on simultaneous write
    step(1, 8'h05, 8'h11); step(3, 8'h05, 8'h3C); step(2, 8'h05, 0);
    // priority between slots, and an out-of-range slot index
    step(0, 0, 0, 1, 0, 1, 2'b00, 8'h30, 3);
    step(0, 0, 0, 1, 2, 1, 2'b01, 8'h30, 3);
    step(0, 0, 0, 1, 3, 1, 2'b01, 8'h30, 4);
    step(1, 8'h30, 8'hFF); step(2, 8'h30, 0); step(1, 8'h30, 8'h00); step(2, 8'h30, 0);
    // back-to-back reads
    for (int i = 0; i < 6; i++) step(2, AW'(8'h30 + i % 2), 0);
    // randomized traffic on a small address window
    for (int i = 0; i < 400; i++) begin
      bit fw = $urandom_range(0, 7) == 0;
      step(CW'($urandom_range(0, 3)), AW'($urandom_range(0, 7)), DW'($urandom),
           fw, $urandom_range(0, 3), bit'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           AW'($urandom_range(0, 7)), BW'($urandom_range(0, 7)), bit'($urandom_range(0, 1)));
    end
    // reset with reads in flight
    step(1, 8'h02, 8'h00, 1, 0, 1, 2'b01, 8'h02, 0);
    step(2, 8'h02, 0); step(2, 8'h02, 0);
    cmd_in = '0;
    do_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) step(0, 0, 0);
    step(1, 8'h02, 8'h00); step(2, 8'h02, 0);
    repeat (5) step(0, 0, 0);
    chk("q1 drained", q1.size(), 0);
    chk("q2 drained", q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
